branch_predictor_ctrl: RTL and testbench
========================================

// Module: branch_predictor_ctrl
// PURPOSE
//   Bimodal branch predictor and redirect controller that drives the PC-select datapath.
//   IF stage: predicts conditional branches from a table of 2-bit counters.
//   EX stage: resolves each branch, updates the table and raises miss_o with the recovery PC.
//   Holds a pending redirect across pipeline stalls so that no recovery is lost.
// PARAMETERS
//   BHT_ENTRIES  32  number of 2-bit counters; must be a power of 2, minimum 4
//   INDEX_W      $clog2(BHT_ENTRIES)  table index width (derived; do not override)
// PORTS
//   clk               in   1   rising-edge clock
//   rst_n             in   1   synchronous active-low reset
//   stall_i           in   1   pipeline stall; freezes table updates and holds the redirect
//   IF_PC_i           in   32  PC of the instruction in IF
//   IF_branch_i       in   1   IF instruction is a conditional branch
//   predict_taken_o   out  1   IF prediction (feeds the IF PC-select as "branch")
//   EX_branch_i       in   1   EX holds a valid conditional branch
//   EX_PC_i           in   32  PC of the EX branch
//   EX_taken_i        in   1   resolved branch outcome
//   EX_pred_taken_i   in   1   prediction made for this branch, carried down the pipeline
//   EX_PC_target_i    in   32  branch target (PC + imm)
//   EX_PC_plus_i      in   32  fall-through PC (PC + 4)
//   miss_o            out  1   redirect request to the PC mux
//   PC_branch_o       out  32  recovery PC while miss_o = 1, else 0
//   flush_o           out  1   flush IF/ID; equals miss_o
//   branch_cnt_o      out  32  resolved-branch count (feature-gated)
//   miss_cnt_o        out  32  mispredict count (feature-gated)
// BEHAVIOUR
//   - Reset: every counter = 2'b01 (weakly not-taken); FSM = IDLE; pending PC = 0.
//     All outputs are 0 during reset and on the first cycle after it.
//   - Index = PC[INDEX_W+1:2]; PC[1:0] is ignored.
//   - Prediction: combinational. predict_taken_o = IF_branch_i & bht[idx_if][1].
//   - Read-during-write to the same index returns the old counter value.
//     The update is visible on the next cycle.
//   - Update: at the clock edge when EX_branch_i & !stall_i & state==IDLE.
//     Counter saturates: taken -> +1 capped at 2'b11; not-taken -> -1 floored at 2'b00.
//   - Mispredict: mis = EX_branch_i & (EX_taken_i != EX_pred_taken_i).
//     recov = EX_taken_i ? EX_PC_target_i : EX_PC_plus_i.
//   - FSM:
//     IDLE: miss_o = mis, PC_branch_o = recov, both combinational (zero-latency redirect).
//       If mis & stall_i: latch recov into pend_pc and go to HOLD. The counter is updated
//       once, on this edge, regardless of the stall.
//     HOLD: miss_o = 1, PC_branch_o = pend_pc. EX inputs are ignored and no table update
//       occurs. Return to IDLE on the first edge with !stall_i.
//   - Exactly one table update per resolved branch.
//     HOLD never re-updates, including a branch that stalls for multiple cycles.
//   - Simultaneous IF predict and EX update to the same entry: the IF prediction uses the
//     pre-update value.
//   - Reset asserted in HOLD: return to IDLE and clear pend_pc. The lost redirect is
//     acceptable because the pipeline is reset too.
// CONFIGURATION
//   BPU_PERF_CNT_EN defined:
//     - branch_cnt_o increments on every table update.
//     - miss_cnt_o increments on every update with mis = 1.
//     - Both saturate at 32'hFFFF_FFFF and reset to 0.
//   BPU_PERF_CNT_EN undefined:
//     - Both ports are tied to 32'd0 and no counter flops are inferred.
// STRUCTURE
//   - Package bpu_pkg:
//     - Counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
//     - BHT_RST = WNT.
//     - FSM enum {IDLE, HOLD}.
//     - Function sat_update(cnt, taken).
//   - Sub-module bpu_bht: counter array with one async read port (IF) and one sync write
//     port (EX), plus sync reset of all entries.
//   - This module holds the FSM, pend_pc, the redirect muxing and the optional counters.
// TESTING
//   1. Reset, then IF_PC_i=0x40 with IF_branch_i=1 -> predict_taken_o=0
//      (entry 16 = 2'b01).
//   2. EX branch at PC 0x40, taken, pred=0, target=0x100, no stall:
//      -> same cycle miss_o=1, PC_branch_o=0x100.
//      -> next cycle IF_PC_i=0x40 predicts 1.
//   3. Three taken updates at 0x40 -> counter is 2'b11.
//      A further taken update holds it at 2'b11.
//      Four not-taken updates -> counter reaches 2'b00 and stays there.
//   4. Mispredict (not-taken, pred=1, plus=0x44) with stall_i=1 for 3 cycles:
//      -> miss_o=1 and PC_branch_o=0x44 for all 3 cycles plus the release cycle.
//      -> exactly one counter decrement.
//   5. IF and EX on the same index in the same cycle -> IF sees the old value.
//      rst_n low in HOLD -> miss_o=0 on the next cycle.
//   6. BPU_PERF_CNT_EN defined, 10 branches with 3 mispredicts -> branch_cnt_o=10,
//      miss_cnt_o=3. Macro undefined -> both read 0.

Source files
------------

// File: rtl/bpu_pkg.sv
// Shared types and helpers for the bimodal branch predictor:
// 2-bit counter encodings, the redirect FSM states and the counter update rule.
package bpu_pkg;

   typedef logic [1:0] bht_cnt_t;

   localparam bht_cnt_t SNT     = 2'b00;  // strongly not-taken
   localparam bht_cnt_t WNT     = 2'b01;  // weakly not-taken
   localparam bht_cnt_t WT      = 2'b10;  // weakly taken
   localparam bht_cnt_t ST      = 2'b11;  // strongly taken
   localparam bht_cnt_t BHT_RST = WNT;

   localparam int PC_W = 32;

   // IDLE: redirects pass straight through; HOLD: a stalled redirect is replayed
   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } bpu_state_e;

   // Saturating 2-bit counter step
   function automatic bht_cnt_t sat_update(input bht_cnt_t cnt, input logic taken);
      bht_cnt_t res;
      res = cnt;
      if (taken) begin
         if (cnt != ST) res = cnt + 2'b01;
      end else begin
         if (cnt != SNT) res = cnt - 2'b01;
      end
      return res;
   endfunction

endpackage

// File: rtl/bpu_bht.sv
// Branch history table: array of 2-bit saturating counters.
// One asynchronous read port (IF prediction) and one synchronous
// read-modify-write port (EX update). A read of the entry being written
// in the same cycle returns the old value; the new value is visible next cycle.
module bpu_bht
   import bpu_pkg::*;
#(
   parameter int ENTRIES = 32,
   parameter int INDEX_W = $clog2(ENTRIES)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [INDEX_W-1:0] rd_idx_i,
   output bht_cnt_t           rd_cnt_o,
   input  logic               wr_en_i,
   input  logic [INDEX_W-1:0] wr_idx_i,
   input  logic               wr_taken_i
);

   bht_cnt_t bht_q [ENTRIES];

   // Reset every counter to weakly not-taken; otherwise step the written entry
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            bht_q[i] <= BHT_RST;
         end
      end else if (wr_en_i) begin
         bht_q[wr_idx_i] <= sat_update(bht_q[wr_idx_i], wr_taken_i);
      end
   end

   assign rd_cnt_o = bht_q[rd_idx_i];

endmodule

// File: rtl/branch_predictor_ctrl.sv
// Bimodal branch predictor and redirect controller for the PC-select datapath.
// IF: predicts conditional branches from the counter table (bpu_bht).
// EX: resolves branches, updates the table once per branch and raises a redirect
// with the recovery PC. A redirect raised while the pipeline is stalled is held
// in HOLD until the stall drops, so no recovery is lost.
// Optional feature macro: BPU_PERF_CNT_EN (resolved-branch / mispredict counters).
//
// Handshake: miss_o/PC_branch_o are a level request to the PC mux, valid whenever
// miss_o = 1; the request is considered consumed on the first clock edge with
// stall_i = 0. While stall_i = 1 the request and its PC are held stable.
module branch_predictor_ctrl
   import bpu_pkg::*;
#(
   parameter int BHT_ENTRIES = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall_i,
   input  logic [PC_W-1:0] IF_PC_i,
   input  logic            IF_branch_i,
   output logic            predict_taken_o,
   input  logic            EX_branch_i,
   input  logic [PC_W-1:0] EX_PC_i,
   input  logic            EX_taken_i,
   input  logic            EX_pred_taken_i,
   input  logic [PC_W-1:0] EX_PC_target_i,
   input  logic [PC_W-1:0] EX_PC_plus_i,
   output logic            miss_o,
   output logic [PC_W-1:0] PC_branch_o,
   output logic            flush_o,
   output logic [31:0]     branch_cnt_o,
   output logic [31:0]     miss_cnt_o
);

   localparam int INDEX_W = $clog2(BHT_ENTRIES);

   bpu_state_e        state_q, state_d;
   logic [PC_W-1:0]   pend_pc_q, pend_pc_d;
   logic [INDEX_W-1:0] idx_if, idx_ex;
   bht_cnt_t          cnt_if;
   logic              mis;
   logic [PC_W-1:0]   recov;
   logic              bht_we;

   // Word-aligned index: PC[1:0] and the bits above the index do not select an entry
   assign idx_if = IF_PC_i[INDEX_W+1:2];
   assign idx_ex = EX_PC_i[INDEX_W+1:2];

   logic unused_pc_bits;
   assign unused_pc_bits = ^{IF_PC_i[PC_W-1:INDEX_W+2], IF_PC_i[1:0],
                             EX_PC_i[PC_W-1:INDEX_W+2], EX_PC_i[1:0]};

   assign mis   = EX_branch_i & (EX_taken_i != EX_pred_taken_i);
   assign recov = EX_taken_i ? EX_PC_target_i : EX_PC_plus_i;

   // A resolved branch updates once: normally when not stalled, or on the edge that
   // parks its mispredict in HOLD. HOLD itself never updates.
   assign bht_we = rst_n & (state_q == IDLE) & EX_branch_i & (~stall_i | mis);

   bpu_bht #(
      .ENTRIES (BHT_ENTRIES),
      .INDEX_W (INDEX_W)
   ) u_bht (
      .clk        (clk),
      .rst_n      (rst_n),
      .rd_idx_i   (idx_if),
      .rd_cnt_o   (cnt_if),
      .wr_en_i    (bht_we),
      .wr_idx_i   (idx_ex),
      .wr_taken_i (EX_taken_i)
   );

   assign predict_taken_o = rst_n & IF_branch_i & cnt_if[1];

   // State register and pending recovery PC
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pend_pc_q <= '0;
      end else begin
         state_q   <= state_d;
         pend_pc_q <= pend_pc_d;
      end
   end

   // Next state: park a stalled mispredict in HOLD, release on the first unstalled edge
   always_comb begin
      state_d   = state_q;
      pend_pc_d = pend_pc_q;
      case (state_q)
         IDLE: begin
            if (mis && stall_i) begin
               state_d   = HOLD;
               pend_pc_d = recov;
            end
         end
         HOLD: begin
            if (!stall_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Redirect outputs: pass-through in IDLE, replay of the parked PC in HOLD
   always_comb begin
      miss_o      = 1'b0;
      PC_branch_o = '0;
      if (rst_n) begin
         case (state_q)
            IDLE: begin
               miss_o      = mis;
               PC_branch_o = mis ? recov : '0;
            end
            HOLD: begin
               miss_o      = 1'b1;
               PC_branch_o = pend_pc_q;
            end
            default: begin
               miss_o      = 1'b0;
               PC_branch_o = '0;
            end
         endcase
      end
   end

   assign flush_o = miss_o;

`ifdef BPU_PERF_CNT_EN
   logic [31:0] branch_cnt_q, branch_cnt_d;
   logic [31:0] miss_cnt_q, miss_cnt_d;

   // Saturating event counts, stepped on each table update
   always_comb begin
      branch_cnt_d = branch_cnt_q;
      miss_cnt_d   = miss_cnt_q;
      if (bht_we) begin
         if (branch_cnt_q != 32'hFFFF_FFFF) branch_cnt_d = branch_cnt_q + 32'd1;
         if (mis && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_d = miss_cnt_q + 32'd1;
      end
   end

   // Counter registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         branch_cnt_q <= '0;
         miss_cnt_q   <= '0;
      end else begin
         branch_cnt_q <= branch_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
      end
   end

   assign branch_cnt_o = rst_n ? branch_cnt_q : 32'd0;
   assign miss_cnt_o   = rst_n ? miss_cnt_q   : 32'd0;
`else
   assign branch_cnt_o = 32'd0;
   assign miss_cnt_o   = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predictor_ctrl.sv
// Bench for branch_predictor_ctrl: directed scenarios plus randomized traffic,
// all checked against a behavioural model of the predictor kept in the bench.
module tb_branch_predictor_ctrl;

   logic        clk;
   logic        rst_n;
   logic        stall_i;
   logic [31:0] IF_PC_i;
   logic        IF_branch_i;
   logic        predict_taken_o;
   logic        EX_branch_i;
   logic [31:0] EX_PC_i;
   logic        EX_taken_i;
   logic        EX_pred_taken_i;
   logic [31:0] EX_PC_target_i;
   logic [31:0] EX_PC_plus_i;
   logic        miss_o;
   logic [31:0] PC_branch_o;
   logic        flush_o;
   logic [31:0] branch_cnt_o;
   logic [31:0] miss_cnt_o;

   branch_predictor_ctrl #(.BHT_ENTRIES(32)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .stall_i         (stall_i),
      .IF_PC_i         (IF_PC_i),
      .IF_branch_i     (IF_branch_i),
      .predict_taken_o (predict_taken_o),
      .EX_branch_i     (EX_branch_i),
      .EX_PC_i         (EX_PC_i),
      .EX_taken_i      (EX_taken_i),
      .EX_pred_taken_i (EX_pred_taken_i),
      .EX_PC_target_i  (EX_PC_target_i),
      .EX_PC_plus_i    (EX_PC_plus_i),
      .miss_o          (miss_o),
      .PC_branch_o     (PC_branch_o),
      .flush_o         (flush_o),
      .branch_cnt_o    (branch_cnt_o),
      .miss_cnt_o      (miss_cnt_o)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- scoreboard counters ----------------
   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Counters held as integers 0..3; a pending redirect is a flag plus a PC.
   int          m_ctr [32];
   bit          m_pending;
   logic [31:0] m_pend_pc;
   logic [31:0] m_bcnt;
   logic [31:0] m_mcnt;

   function automatic int pc_index(input logic [31:0] pc);
      return int'((pc >> 2) % 32);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_ctr[i] = 1;
      m_pending = 1'b0;
      m_pend_pc = 32'd0;
      m_bcnt    = 32'd0;
      m_mcnt    = 32'd0;
   endtask

   // Evaluate expected outputs from the present inputs and compare at the negedge
   task automatic half();
      logic        e_pred, e_miss, mis;
      logic [31:0] e_pc, e_b, e_m;
      @(negedge clk);
      mis    = EX_branch_i && (EX_taken_i != EX_pred_taken_i);
      e_pred = 1'b0; e_miss = 1'b0; e_pc = 32'd0; e_b = 32'd0; e_m = 32'd0;
      if (rst_n) begin
         e_pred = IF_branch_i && (m_ctr[pc_index(IF_PC_i)] >= 2);
         if (m_pending) begin
            e_miss = 1'b1;
            e_pc   = m_pend_pc;
         end else if (mis) begin
            e_miss = 1'b1;
            e_pc   = EX_taken_i ? EX_PC_target_i : EX_PC_plus_i;
         end
`ifdef BPU_PERF_CNT_EN
         e_b = m_bcnt;
         e_m = m_mcnt;
`endif
      end
      check("predict", {31'd0, predict_taken_o}, {31'd0, e_pred});
      check("miss",    {31'd0, miss_o},          {31'd0, e_miss});
      check("pc",      PC_branch_o,              e_pc);
      check("flush",   {31'd0, flush_o},         {31'd0, e_miss});
      check("bcnt",    branch_cnt_o,             e_b);
      check("mcnt",    miss_cnt_o,               e_m);
   endtask

   // Apply the edge to the model, then advance to just after the DUT edge
   task automatic finish_cycle();
      bit mis;
      int k;
      mis = EX_branch_i && (EX_taken_i != EX_pred_taken_i);
      if (!rst_n) begin
         model_reset();
      end else if (m_pending) begin
         if (!stall_i) m_pending = 1'b0;
      end else if (EX_branch_i && (!stall_i || mis)) begin
         k = pc_index(EX_PC_i);
         if (EX_taken_i) m_ctr[k] = (m_ctr[k] == 3) ? 3 : m_ctr[k] + 1;
         else            m_ctr[k] = (m_ctr[k] == 0) ? 0 : m_ctr[k] - 1;
         if (m_bcnt != 32'hFFFF_FFFF) m_bcnt = m_bcnt + 1;
         if (mis && m_mcnt != 32'hFFFF_FFFF) m_mcnt = m_mcnt + 1;
         if (mis && stall_i) begin
            m_pending = 1'b1;
            m_pend_pc = EX_taken_i ? EX_PC_target_i : EX_PC_plus_i;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      half();
      finish_cycle();
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_idle();
      stall_i = 1'b0; IF_branch_i = 1'b0; IF_PC_i = 32'd0;
      EX_branch_i = 1'b0; EX_PC_i = 32'd0; EX_taken_i = 1'b0; EX_pred_taken_i = 1'b0;
      EX_PC_target_i = 32'd0; EX_PC_plus_i = 32'd0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic ex_br(input logic [31:0] pc, input logic taken, input logic predt);
      EX_branch_i = 1'b1; EX_PC_i = pc; EX_taken_i = taken; EX_pred_taken_i = predt;
      EX_PC_target_i = 32'h100; EX_PC_plus_i = pc + 32'd4;
      step();
      EX_branch_i = 1'b0;
   endtask

   // One quiet EX cycle, checking the IF prediction for IF_PC_i
   task automatic idle_chk(input string tag, input logic exp);
      EX_branch_i = 1'b0;
      half();
      check(tag, {31'd0, predict_taken_o}, {31'd0, exp});
      finish_cycle();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0;
      drive_idle();
      model_reset();
      @(posedge clk);
      #1;
      do_reset();

      // First cycle after reset: all outputs quiet
      half();
      check("post_rst_miss", {31'd0, miss_o}, 32'd0);
      finish_cycle();

      // Reset counter at entry 16 predicts not-taken
      IF_PC_i = 32'h40; IF_branch_i = 1'b1;
      half();
      check("t1_pred", {31'd0, predict_taken_o}, 32'd0);
      finish_cycle();

      // Taken mispredict: same-cycle redirect, IF sees old counter, new value next cycle
      EX_branch_i = 1'b1; EX_PC_i = 32'h40; EX_taken_i = 1'b1; EX_pred_taken_i = 1'b0;
      EX_PC_target_i = 32'h100; EX_PC_plus_i = 32'h44;
      half();
      check("t2_miss", {31'd0, miss_o}, 32'd1);
      check("t2_pc", PC_branch_o, 32'h100);
      check("t5_if_old", {31'd0, predict_taken_o}, 32'd0);
      finish_cycle();
      idle_chk("t2_pred_next", 1'b1);

      // Saturation high and low at entry 16
      do_reset();
      IF_PC_i = 32'h40; IF_branch_i = 1'b1;
      ex_br(32'h40, 1'b1, 1'b0);
      ex_br(32'h40, 1'b1, 1'b1);
      ex_br(32'h40, 1'b1, 1'b1);
      ex_br(32'h40, 1'b1, 1'b1);
      idle_chk("t3_sat_hi", 1'b1);
      ex_br(32'h40, 1'b0, 1'b1);
      idle_chk("t3_dec1", 1'b1);
      ex_br(32'h40, 1'b0, 1'b1);
      ex_br(32'h40, 1'b0, 1'b0);
      ex_br(32'h40, 1'b0, 1'b0);
      idle_chk("t3_floor", 1'b0);
      ex_br(32'h43, 1'b1, 1'b0);
      ex_br(32'h40, 1'b1, 1'b0);
      idle_chk("t3_floor_up", 1'b1);

      // Stalled mispredict held for 3 stall cycles plus the release cycle; one decrement
      EX_branch_i = 1'b1; EX_PC_i = 32'h40; EX_taken_i = 1'b0; EX_pred_taken_i = 1'b1;
      EX_PC_target_i = 32'h100; EX_PC_plus_i = 32'h44; stall_i = 1'b1;
      for (int c = 0; c < 4; c++) begin
         if (c == 3) stall_i = 1'b0;
         half();
         check("t4_hold_miss", {31'd0, miss_o}, 32'd1);
         check("t4_hold_pc", PC_branch_o, 32'h44);
         finish_cycle();
         EX_taken_i = 1'b1; EX_pred_taken_i = 1'b0; EX_PC_target_i = 32'h999;
      end
      EX_branch_i = 1'b0;
      half();
      check("t4_release", {31'd0, miss_o}, 32'd0);
      finish_cycle();
      ex_br(32'h40, 1'b1, 1'b0);
      idle_chk("t4_one_dec", 1'b1);

      // Reset while in HOLD drops the redirect
      ex_br(32'h80, 1'b0, 1'b1);
      EX_branch_i = 1'b1; EX_PC_i = 32'h80; EX_taken_i = 1'b1; EX_pred_taken_i = 1'b0;
      stall_i = 1'b1;
      step();
      EX_branch_i = 1'b0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1; stall_i = 1'b0;
      half();
      check("t5_rst_hold", {31'd0, miss_o}, 32'd0);
      finish_cycle();

      // Ten branches, three mispredicts
      do_reset();
      for (int b = 0; b < 10; b++) begin
         ex_br(32'h200 + 32'(b * 4), 1'b1, (b % 3 == 0 && b < 9) ? 1'b0 : 1'b1);
      end
      half();
`ifdef BPU_PERF_CNT_EN
      check("t6_bcnt", branch_cnt_o, 32'd10);
      check("t6_mcnt", miss_cnt_o, 32'd3);
`else
      check("t6_bcnt", branch_cnt_o, 32'd0);
      check("t6_mcnt", miss_cnt_o, 32'd0);
`endif
      finish_cycle();

      // Randomized traffic with aliasing PCs
      for (int n = 0; n < 3000; n++) begin
         rst_n           = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
         stall_i         = ($urandom_range(0, 3) == 0);
         IF_branch_i     = $urandom_range(0, 1);
         IF_PC_i         = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
         EX_branch_i     = ($urandom_range(0, 2) != 0);
         EX_PC_i         = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
         EX_taken_i      = $urandom_range(0, 1);
         EX_pred_taken_i = $urandom_range(0, 1);
         EX_PC_target_i  = $urandom;
         EX_PC_plus_i    = $urandom;
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
